spi_reg_slave: RTL and testbench
================================

SPI_REG_SLAVE -- requirements
Module: spi_reg_slave

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, entries per TX/RX FIFO; power of two, minimum 2.
REQ-002 S_SYSCLK  in  1  sole clock; all logic on rising edge.
REQ-003 S_RESET  in  1  reset, synchronous, active-high.
REQ-004 S_AWADDR  in  8  write address.
REQ-005 S_WDATA  in  32  write data.
REQ-006 S_WSTRB  in  4  byte enables for S_WDATA.
REQ-007 S_REG_WEN  in  1  write strobe, one cycle per write.
REQ-008 S_ARADDR  in  8  read address.
REQ-009 S_REG_RDEN  in  1  read strobe, one cycle per read.
REQ-010 S_RDATA  out  32  registered read data.
REQ-011 SPMODE_O  out  32  current SPMODE register.
REQ-012 SPCOM_O  out  32  current SPCOM register.
REQ-013 XFER_START  out  1  one-cycle pulse per SPCOM write.
REQ-014 TX_DATA  out  32  TX FIFO head word.
REQ-015 TX_EMPTY  out  1  TX FIFO empty.
REQ-016 TX_POP  in  1  shift core consumes TX head.
REQ-017 RX_DATA  in  32  received word from shift core.
REQ-018 RX_PUSH  in  1  store RX_DATA into RX FIFO.
REQ-019 XFER_DONE  in  1  one-cycle transfer-complete pulse from shift core.
REQ-020 IRQ  out  1  registered interrupt, |(SPIE & SPIM).

Function
REQ-021 Map: SPMODE 0x00 RW, SPIE 0x04 status/W1C, SPIM 0x08 RW, SPCOM 0x0C RW, SPITF 0x10 WO, SPIRF 0x14 RO; other addresses: writes ignored, reads return 0.
REQ-022 RW writes update only bytes with S_WSTRB bit set; S_WSTRB==0 is a no-op for every address.
REQ-023 SPITF write with any strobe set pushes full S_WDATA into TX FIFO; if full and no TX_POP same cycle, word dropped, SPIE.TXOVF set.
REQ-024 Read: S_RDATA loads selected value on the edge sampling S_REG_RDEN=1 (1-cycle latency), holds until next read; SPITF reads 0.
REQ-025 SPIRF read returns RX head and pops it that edge; empty RX FIFO returns 0, pointers unchanged.
REQ-026 RX_PUSH when full and no SPIRF pop same cycle: word dropped, SPIE.RXOVF set; with simultaneous pop, both occur, no overflow.
REQ-027 TX_POP on empty TX FIFO ignored; push and pop same cycle on non-empty non-full FIFO keep count unchanged.
REQ-028 SPIE bits: [0] RNE, [1] TNF, [2] RXF, [3] TXE live status (writes ignored); [4] DON, [5] RXOVF, [6] TXOVF sticky, clear by writing 1; others read 0.
REQ-029 Sticky set event and W1C in same cycle: set wins.
REQ-030 XFER_START asserts cycle after SPCOM write accepted, exactly one cycle; back-to-back writes give back-to-back pulses.
REQ-031 IRQ registered, updates one cycle after SPIE or SPIM change.
REQ-032 Pointer wrap-around modulo FIFO_DEPTH; full/empty distinguished by count, no lost entry.

Reset
REQ-033 On S_RESET=1 at an edge: SPMODE=SPMODE_DEF (0x0000_100F), SPIE sticky bits, SPIM, SPCOM, S_RDATA = 0; XFER_START, IRQ = 0; both FIFOs flushed (TX_EMPTY=1).
REQ-034 Reset mid-operation discards pending FIFO contents and any same-cycle write/read/push/pop.

Structure
REQ-035 Register addresses, SPMODE_DEF, SPIE bit indices in shared definitions file spi-reg-def.v, used by this block and bus masters.
REQ-036 One sub-module spi_reg_fifo (parameterised synchronous FIFO: push, pop, data, full, empty, count) instantiated for TX and RX.

Verification
REQ-037 Reset, read 0x00 -> 0x0000_100F; read 0x04 -> 0x0000_000A (TNF, TXE); IRQ=0.
REQ-038 Write SPIM 0xFFFF_FFFF strobe 4'b0001, read back -> 0x0000_00FF.
REQ-039 Push 5 SPITF words with FIFO_DEPTH=4, no TX_POP -> first 4 at TX_DATA in order under TX_POP, SPIE.TXOVF=1; write 0x40 to SPIE -> TXOVF cleared.
REQ-040 RX_PUSH 0xA5A5_0001 and 0xA5A5_0002, read SPIRF twice then once more -> 0xA5A5_0001, 0xA5A5_0002, 0; RNE ends 0.
REQ-041 SPIM=0x10, pulse XFER_DONE -> IRQ=1 one cycle later; W1C 0x10 in same cycle as second XFER_DONE -> DON stays 1.
REQ-042 Write SPCOM 0x0000_0003 -> XFER_START single pulse next cycle, SPCOM_O=0x0000_0003; assert S_RESET mid-transfer -> all outputs at reset values.

Source files
------------

// File: rtl/spi_reg_slave_pkg.sv
// Shared register-map definitions for the SPI register slave and its bus masters.
// Contents: register byte addresses, SPMODE reset value, SPIE bit indices,
// a register-select enum with its address decoder, and a byte-strobe merge helper.
package spi_reg_slave_pkg;

  localparam logic [7:0] ADDR_SPMODE = 8'h00;
  localparam logic [7:0] ADDR_SPIE   = 8'h04;
  localparam logic [7:0] ADDR_SPIM   = 8'h08;
  localparam logic [7:0] ADDR_SPCOM  = 8'h0C;
  localparam logic [7:0] ADDR_SPITF  = 8'h10;
  localparam logic [7:0] ADDR_SPIRF  = 8'h14;

  localparam logic [31:0] SPMODE_DEF = 32'h0000_100F;

  // SPIE bit positions: [3:0] live status, [6:4] sticky W1C events
  localparam int SPIE_RNE   = 0;
  localparam int SPIE_TNF   = 1;
  localparam int SPIE_RXF   = 2;
  localparam int SPIE_TXE   = 3;
  localparam int SPIE_DON   = 4;
  localparam int SPIE_RXOVF = 5;
  localparam int SPIE_TXOVF = 6;

  typedef enum logic [2:0] {
    SEL_SPMODE,
    SEL_SPIE,
    SEL_SPIM,
    SEL_SPCOM,
    SEL_SPITF,
    SEL_SPIRF,
    SEL_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [7:0] addr);
    case (addr)
      ADDR_SPMODE: decode_addr = SEL_SPMODE;
      ADDR_SPIE:   decode_addr = SEL_SPIE;
      ADDR_SPIM:   decode_addr = SEL_SPIM;
      ADDR_SPCOM:  decode_addr = SEL_SPCOM;
      ADDR_SPITF:  decode_addr = SEL_SPITF;
      ADDR_SPIRF:  decode_addr = SEL_SPIRF;
      default:     decode_addr = SEL_NONE;
    endcase
  endfunction

  // Replace only the bytes whose strobe bit is set
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    for (int b = 0; b < 4; b++)
      strb_merge[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
  endfunction

endpackage

// File: rtl/spi_reg_fifo.sv
// Synchronous FIFO used for both the TX and RX word queues.
// Ports:
//   clk_i    clock (rising edge)        srst_i  synchronous active-high flush
//   push_i   write data_i               pop_i   drop head entry
//   data_i   write word                 data_o  head word (valid when !empty_o)
//   full_o / empty_o                    count_o occupied entries (0..DEPTH)
// A pop on empty is ignored. A push when full is accepted only if a pop
// is retiring the head in the same cycle. DEPTH must be a power of two >= 2.
module spi_reg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Storage needs no reset: contents are only visible through count_q
  always_ff @(posedge clk_i) begin
    if (push_ok && !srst_i) mem_q[wptr_q] <= data_i;
  end

  // Pointers are AW bits wide, so wrap modulo DEPTH is implicit
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/spi_reg_slave.sv
// SPI controller register slave: bus-facing register file plus TX/RX word
// FIFOs between the bus and the shift core.
// Ports:
//   S_SYSCLK, S_RESET (sync, active-high)
//   Write bus: S_AWADDR, S_WDATA, S_WSTRB, S_REG_WEN
//   Read bus:  S_ARADDR, S_REG_RDEN, S_RDATA (registered, 1-cycle latency)
//   To core:   SPMODE_O, SPCOM_O, XFER_START, TX_DATA, TX_EMPTY
//   From core: TX_POP, RX_DATA, RX_PUSH, XFER_DONE
//   IRQ:       registered |(SPIE & SPIM)
module spi_reg_slave
  import spi_reg_slave_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        S_SYSCLK,
  input  logic        S_RESET,
  input  logic [7:0]  S_AWADDR,
  input  logic [31:0] S_WDATA,
  input  logic [3:0]  S_WSTRB,
  input  logic        S_REG_WEN,
  input  logic [7:0]  S_ARADDR,
  input  logic        S_REG_RDEN,
  output logic [31:0] S_RDATA,
  output logic [31:0] SPMODE_O,
  output logic [31:0] SPCOM_O,
  output logic        XFER_START,
  output logic [31:0] TX_DATA,
  output logic        TX_EMPTY,
  input  logic        TX_POP,
  input  logic [31:0] RX_DATA,
  input  logic        RX_PUSH,
  input  logic        XFER_DONE,
  output logic        IRQ
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0] spmode_q, spmode_d;
  logic [31:0] spim_q,   spim_d;
  logic [31:0] spcom_q,  spcom_d;
  logic [2:0]  sticky_q, sticky_d;   // {TXOVF, RXOVF, DON}
  logic [31:0] rdata_q,  rdata_d;
  logic        xstart_q, xstart_d;
  logic        irq_q,    irq_d;

  logic        wr_en;
  reg_sel_e    wsel, rsel;
  logic        tx_push, tx_full, tx_empty;
  logic        rx_pop, rx_full, rx_empty;
  logic [31:0] rx_head;
  logic        txovf_set, rxovf_set;
  logic [2:0]  w1c;
  logic [31:0] spie_val;
  logic [CW-1:0] tx_count, rx_count;
  logic        unused_cnt;

  assign unused_cnt = ^{tx_count, rx_count};

  assign wr_en = S_REG_WEN && (S_WSTRB != 4'b0000);
  assign wsel  = decode_addr(S_AWADDR);
  assign rsel  = decode_addr(S_ARADDR);

  assign tx_push = wr_en && (wsel == SEL_SPITF);
  // Only a read that actually returns a word consumes the RX head
  assign rx_pop  = S_REG_RDEN && (rsel == SEL_SPIRF) && !rx_empty;

  // A full FIFO is never empty, so TX_POP here is always a real pop
  assign txovf_set = tx_push && tx_full && !TX_POP;
  assign rxovf_set = RX_PUSH && rx_full && !rx_pop;

  // Sticky bits live in byte 0, so only strobe bit 0 enables the W1C
  assign w1c = (wr_en && (wsel == SEL_SPIE) && S_WSTRB[0]) ? S_WDATA[SPIE_TXOVF:SPIE_DON] : 3'b000;

  always_comb begin
    spie_val = '0;
    spie_val[SPIE_RNE] = !rx_empty;
    spie_val[SPIE_TNF] = !tx_full;
    spie_val[SPIE_RXF] = rx_full;
    spie_val[SPIE_TXE] = tx_empty;
    spie_val[SPIE_TXOVF:SPIE_DON] = sticky_q;
  end

  always_comb begin
    spmode_d = spmode_q;
    spim_d   = spim_q;
    spcom_d  = spcom_q;
    if (wr_en) begin
      case (wsel)
        SEL_SPMODE: spmode_d = strb_merge(spmode_q, S_WDATA, S_WSTRB);
        SEL_SPIM:   spim_d   = strb_merge(spim_q,   S_WDATA, S_WSTRB);
        SEL_SPCOM:  spcom_d  = strb_merge(spcom_q,  S_WDATA, S_WSTRB);
        default: ;
      endcase
    end

    // Set after clear so a same-cycle event wins over W1C
    sticky_d = (sticky_q & ~w1c) | {txovf_set, rxovf_set, XFER_DONE};

    rdata_d = rdata_q;
    if (S_REG_RDEN) begin
      case (rsel)
        SEL_SPMODE: rdata_d = spmode_q;
        SEL_SPIE:   rdata_d = spie_val;
        SEL_SPIM:   rdata_d = spim_q;
        SEL_SPCOM:  rdata_d = spcom_q;
        SEL_SPIRF:  rdata_d = rx_empty ? 32'h0 : rx_head;
        default:    rdata_d = 32'h0;
      endcase
    end

    xstart_d = wr_en && (wsel == SEL_SPCOM);
    // Uses registered SPIE/SPIM, so IRQ trails any change by one cycle
    irq_d    = |(spie_val & spim_q);
  end

  always_ff @(posedge S_SYSCLK) begin
    if (S_RESET) begin
      spmode_q <= SPMODE_DEF;
      spim_q   <= '0;
      spcom_q  <= '0;
      sticky_q <= '0;
      rdata_q  <= '0;
      xstart_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      spmode_q <= spmode_d;
      spim_q   <= spim_d;
      spcom_q  <= spcom_d;
      sticky_q <= sticky_d;
      rdata_q  <= rdata_d;
      xstart_q <= xstart_d;
      irq_q    <= irq_d;
    end
  end

  spi_reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tx_fifo (
    .clk_i   (S_SYSCLK),
    .srst_i  (S_RESET),
    .push_i  (tx_push),
    .pop_i   (TX_POP),
    .data_i  (S_WDATA),
    .data_o  (TX_DATA),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  spi_reg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_rx_fifo (
    .clk_i   (S_SYSCLK),
    .srst_i  (S_RESET),
    .push_i  (RX_PUSH),
    .pop_i   (rx_pop),
    .data_i  (RX_DATA),
    .data_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  assign S_RDATA    = rdata_q;
  assign SPMODE_O   = spmode_q;
  assign SPCOM_O    = spcom_q;
  assign XFER_START = xstart_q;
  assign TX_EMPTY   = tx_empty;
  assign IRQ        = irq_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
module tb_spi_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  awaddr, araddr;
  logic [31:0] wdata, rx_data;
  logic [3:0]  wstrb;
  logic        wen, rden, tx_pop, rx_push, xfer_done;
  logic [31:0] rdata, spmode, spcom, tx_data;
  logic        xfer_start, tx_empty, irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_reg_slave #(.FIFO_DEPTH(4)) dut (
    .S_SYSCLK(clk), .S_RESET(rst),
    .S_AWADDR(awaddr), .S_WDATA(wdata), .S_WSTRB(wstrb), .S_REG_WEN(wen),
    .S_ARADDR(araddr), .S_REG_RDEN(rden), .S_RDATA(rdata),
    .SPMODE_O(spmode), .SPCOM_O(spcom), .XFER_START(xfer_start),
    .TX_DATA(tx_data), .TX_EMPTY(tx_empty), .TX_POP(tx_pop),
    .RX_DATA(rx_data), .RX_PUSH(rx_push), .XFER_DONE(xfer_done), .IRQ(irq)
  );

  // Inputs change and outputs are sampled on the falling edge
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); awaddr = a; wdata = d; wstrb = s; wen = 1'b1;
    @(negedge clk); wen = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); araddr = a; rden = 1'b1;
    @(negedge clk); rden = 1'b0; d = rdata;
  endtask

  task automatic rx_word(input logic [31:0] d);
    @(negedge clk); rx_data = d; rx_push = 1'b1;
    @(negedge clk); rx_push = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
    n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", rdata); end
    n_tests++; if (spmode !== 32'h0000_100F) begin n_fail++; $display("FAIL reset_spmode_o got %h exp 0000100f", spmode); end
    n_tests++; if (spcom !== 32'h0) begin n_fail++; $display("FAIL reset_spcom_o got %h exp 0", spcom); end
    n_tests++; if ({tx_empty, xfer_start, irq} !== 3'b100) begin n_fail++; $display("FAIL reset_flags {txe,xs,irq} got %b exp 100", {tx_empty, xfer_start, irq}); end
    bus_read(8'h00, r);
    n_tests++; if (r !== 32'h0000_100F) begin n_fail++; $display("FAIL reset_read_spmode got %h exp 0000100f", r); end
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_000A) begin n_fail++; $display("FAIL reset_read_spie got %h exp 0000000a", r); end
  endtask

  task automatic test_strobe();
    logic [31:0] r;
    bus_write(8'h08, 32'hFFFF_FFFF, 4'b0001);
    bus_read(8'h08, r);
    n_tests++; if (r !== 32'h0000_00FF) begin n_fail++; $display("FAIL strobe_spim got %h exp 000000ff", r); end
    bus_write(8'h08, 32'h1234_5678, 4'b0000);
    bus_read(8'h08, r);
    n_tests++; if (r !== 32'h0000_00FF) begin n_fail++; $display("FAIL strobe_zero_noop got %h exp 000000ff", r); end
    bus_write(8'h00, 32'hAABB_CCDD, 4'b1010);
    bus_read(8'h00, r);
    n_tests++; if (r !== 32'hAA00_CC0F) begin n_fail++; $display("FAIL strobe_spmode got %h exp aa00cc0f", r); end
    bus_write(8'h08, 32'h0, 4'b1111);
    bus_write(8'h20, 32'hFFFF_FFFF, 4'b1111);
    bus_read(8'h20, r);
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h exp 0", r); end
    bus_read(8'h10, r);
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL spitf_read got %h exp 0", r); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    for (int i = 0; i < 5; i++) bus_write(8'h10, 32'h1000_0011 + i, 4'b1111);
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_0040) begin n_fail++; $display("FAIL tx_full_spie got %h exp 00000040", r); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (tx_data !== 32'h1000_0011 + i) begin n_fail++; $display("FAIL tx_order[%0d] got %h exp %h", i, tx_data, 32'h1000_0011 + i); end
      @(negedge clk); tx_pop = 1'b1;
      @(negedge clk); tx_pop = 1'b0;
    end
    n_tests++; if (tx_empty !== 1'b1) begin n_fail++; $display("FAIL tx_drained got %b exp 1", tx_empty); end
    @(negedge clk); tx_pop = 1'b1;
    @(negedge clk); tx_pop = 1'b0;
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_004A) begin n_fail++; $display("FAIL tx_pop_empty_spie got %h exp 0000004a", r); end
    bus_write(8'h04, 32'h0000_0040, 4'b0001);
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_000A) begin n_fail++; $display("FAIL txovf_w1c got %h exp 0000000a", r); end
  endtask

  task automatic test_rx();
    logic [31:0] r;
    rx_word(32'hA5A5_0001);
    rx_word(32'hA5A5_0002);
    bus_read(8'h14, r);
    n_tests++; if (r !== 32'hA5A5_0001) begin n_fail++; $display("FAIL rx_first got %h exp a5a50001", r); end
    bus_read(8'h14, r);
    n_tests++; if (r !== 32'hA5A5_0002) begin n_fail++; $display("FAIL rx_second got %h exp a5a50002", r); end
    bus_read(8'h14, r);
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read got %h exp 0", r); end
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_000A) begin n_fail++; $display("FAIL rx_rne_clear got %h exp 0000000a", r); end
    // Overflow: fifth push dropped
    for (int i = 0; i < 5; i++) rx_word(32'hB000_0001 + i);
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_002F) begin n_fail++; $display("FAIL rxovf_spie got %h exp 0000002f", r); end
    for (int i = 0; i < 4; i++) begin
      bus_read(8'h14, r);
      n_tests++; if (r !== 32'hB000_0001 + i) begin n_fail++; $display("FAIL rx_ovf_order[%0d] got %h exp %h", i, r, 32'hB000_0001 + i); end
    end
    bus_write(8'h04, 32'h0000_0020, 4'b0001);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    for (int i = 0; i < 4; i++) rx_word(32'hC000_0001 + i);
    // Push into a full FIFO while the bus pops it: both happen, no overflow
    @(negedge clk); araddr = 8'h14; rden = 1'b1; rx_data = 32'hC000_0005; rx_push = 1'b1;
    @(negedge clk); rden = 1'b0; rx_push = 1'b0;
    n_tests++; if (rdata !== 32'hC000_0001) begin n_fail++; $display("FAIL simul_pop got %h exp c0000001", rdata); end
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_000F) begin n_fail++; $display("FAIL simul_spie got %h exp 0000000f", r); end
    for (int i = 0; i < 4; i++) begin
      bus_read(8'h14, r);
      n_tests++; if (r !== 32'hC000_0002 + i) begin n_fail++; $display("FAIL wrap_order[%0d] got %h exp %h", i, r, 32'hC000_0002 + i); end
    end
  endtask

  task automatic test_irq();
    logic [31:0] r;
    bus_write(8'h08, 32'h0000_0010, 4'b0001);
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b exp 0", irq); end
    @(negedge clk); xfer_done = 1'b1;
    @(negedge clk); xfer_done = 1'b0;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_latency got %b exp 0", irq); end
    @(negedge clk);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_assert got %b exp 1", irq); end
    @(negedge clk); awaddr = 8'h04; wdata = 32'h10; wstrb = 4'b0001; wen = 1'b1; xfer_done = 1'b1;
    @(negedge clk); wen = 1'b0; xfer_done = 1'b0;
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_001A) begin n_fail++; $display("FAIL don_set_wins got %h exp 0000001a", r); end
    bus_write(8'h04, 32'h10, 4'b0001);
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_000A) begin n_fail++; $display("FAIL don_w1c got %h exp 0000000a", r); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq); end
    bus_write(8'h08, 32'h0, 4'b1111);
  endtask

  task automatic test_xfer_start();
    logic [31:0] r;
    @(negedge clk); awaddr = 8'h0C; wdata = 32'h3; wstrb = 4'b1111; wen = 1'b1;
    @(negedge clk); wen = 1'b0;
    n_tests++; if (xfer_start !== 1'b1) begin n_fail++; $display("FAIL xstart_pulse got %b exp 1", xfer_start); end
    n_tests++; if (spcom !== 32'h3) begin n_fail++; $display("FAIL spcom_o got %h exp 00000003", spcom); end
    @(negedge clk);
    n_tests++; if (xfer_start !== 1'b0) begin n_fail++; $display("FAIL xstart_single got %b exp 0", xfer_start); end
    @(negedge clk); wdata = 32'h4; wen = 1'b1;
    @(negedge clk); wdata = 32'h5;
    n_tests++; if (xfer_start !== 1'b1) begin n_fail++; $display("FAIL xstart_b2b_1 got %b exp 1", xfer_start); end
    @(negedge clk); wen = 1'b0;
    n_tests++; if (xfer_start !== 1'b1) begin n_fail++; $display("FAIL xstart_b2b_2 got %b exp 1", xfer_start); end
    @(negedge clk);
    n_tests++; if ({xfer_start, spcom} !== {1'b0, 32'h5}) begin n_fail++; $display("FAIL xstart_b2b_end got %b/%h exp 0/00000005", xfer_start, spcom); end
    // Reset in the middle of activity
    bus_write(8'h10, 32'hDEAD_0001, 4'b1111);
    rx_word(32'hDEAD_0002);
    bus_write(8'h08, 32'hFF, 4'b0001);
    bus_read(8'h00, r);
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b exp 1", irq); end
    @(negedge clk); rst = 1'b1; awaddr = 8'h0C; wdata = 32'h7; wstrb = 4'b1111; wen = 1'b1; rx_push = 1'b1;
    @(negedge clk); rst = 1'b0; wen = 1'b0; rx_push = 1'b0;
    n_tests++; if ({tx_empty, xfer_start, irq} !== 3'b100) begin n_fail++; $display("FAIL midrst_flags {txe,xs,irq} got %b exp 100", {tx_empty, xfer_start, irq}); end
    n_tests++; if ({spmode, spcom, rdata} !== {32'h0000_100F, 32'h0, 32'h0}) begin n_fail++; $display("FAIL midrst_regs got %h/%h/%h exp 0000100f/0/0", spmode, spcom, rdata); end
    bus_read(8'h14, r);
    n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL midrst_rx_flushed got %h exp 0", r); end
    bus_read(8'h04, r);
    n_tests++; if (r !== 32'h0000_000A) begin n_fail++; $display("FAIL midrst_spie got %h exp 0000000a", r); end
  endtask

  initial begin
    rst = 1'b1; awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; wen = 1'b0; rden = 1'b0;
    tx_pop = 1'b0; rx_data = '0; rx_push = 1'b0; xfer_done = 1'b0;
    test_reset();
    test_strobe();
    test_tx_overflow();
    test_rx();
    test_back_to_back();
    test_irq();
    test_xfer_start();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
